// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: registered coordinates, one-step lookahead,
// sync/blank qualifiers, line/frame strobes and a frame counter, advancing on vtg_ce.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FCW      = 8
) (
  input  logic           pixel_clk,
  input  logic           reset_n,
  input  logic           vtg_ce,
  output logic [CW-1:0]  pixel_x,
  output logic [CW-1:0]  pixel_y,
  output logic [CW-1:0]  next_pixel_x,
  output logic [CW-1:0]  next_pixel_y,
  output logic           hsync,
  output logic           vsync,
  output logic           hblank,
  output logic           vblank,
  output logic           video_on,
  output logic           next_video_on,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Successor of the lookahead position; becomes next_* on an advancing edge.
  logic [CW-1:0] after_x;
  logic [CW-1:0] after_y;
  logic          x_wrap;

  always_comb begin
    x_wrap  = (next_pixel_x == H_LAST);
    after_x = x_wrap ? '0 : next_pixel_x + CW'(1);
    after_y = next_pixel_y;
    if (x_wrap) begin
      after_y = (next_pixel_y == V_LAST) ? '0 : next_pixel_y + CW'(1);
    end
  end

  // Qualifiers are evaluated at next_* so they land on the same edge as the coordinates.
  logic in_hsync;
  logic in_vsync;
  logic in_hblank;
  logic in_vblank;
  logic after_visible;
  logic at_origin;

  assign in_hsync      = (next_pixel_x >= HS_FIRST) && (next_pixel_x <= HS_LAST);
  assign in_vsync      = (next_pixel_y >= VS_FIRST) && (next_pixel_y <= VS_LAST);
  assign in_hblank     = (next_pixel_x >= H_ACT);
  assign in_vblank     = (next_pixel_y >= V_ACT);
  assign after_visible = (after_x < H_ACT) && (after_y < V_ACT);
  assign at_origin     = (next_pixel_x == '0) && (next_pixel_y == '0);

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_x       <= '0;
      pixel_y       <= '0;
      next_pixel_x  <= CW'(1);
      next_pixel_y  <= '0;
      hsync         <= ~HS_POL;
      vsync         <= ~VS_POL;
      hblank        <= 1'b0;
      vblank        <= 1'b0;
      video_on      <= 1'b1;
      next_video_on <= 1'b1;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      frame_count   <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (vtg_ce) begin
        pixel_x       <= next_pixel_x;
        pixel_y       <= next_pixel_y;
        next_pixel_x  <= after_x;
        next_pixel_y  <= after_y;
        hsync         <= in_hsync ? HS_POL : ~HS_POL;
        vsync         <= in_vsync ? VS_POL : ~VS_POL;
        hblank        <= in_hblank;
        vblank        <= in_vblank;
        video_on      <= !in_hblank && !in_vblank;
        next_video_on <= after_visible;
        line_start    <= (next_pixel_x == '0);
        frame_start   <= at_origin;
        if (at_origin) begin
          frame_count <= frame_count + FCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three parameter sets (default 800x525, tiny 8x6 with
// positive syncs and 2-bit frame counter, 8x525) checked every cycle against a raster model.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b1;
  logic ce      = 1'b1;
  logic toggle  = 1'b0;
  logic sb_en   = 1'b0;

  logic [9:0] px [3];
  logic [9:0] py [3];
  logic [9:0] npx[3];
  logic [9:0] npy[3];
  logic hs[3], vs[3], hb[3], vb[3], von[3], nvon[3], ls[3], fs[3];
  logic [7:0] fc_d, fc_m;
  logic [1:0] fc_s;

  localparam int HA [3] = '{640, 4, 4};
  localparam int HF [3] = '{16, 1, 1};
  localparam int HS [3] = '{96, 2, 2};
  localparam int HT [3] = '{800, 8, 8};
  localparam int VA [3] = '{480, 3, 480};
  localparam int VF [3] = '{10, 1, 10};
  localparam int VS [3] = '{2, 1, 2};
  localparam int VT [3] = '{525, 6, 525};
  localparam int FM [3] = '{256, 4, 256};
  localparam bit HP [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit VP [3] = '{1'b0, 1'b1, 1'b0};

  video_timing_gen dut_d (
    .pixel_clk(clk), .reset_n(reset_n), .vtg_ce(ce),
    .pixel_x(px[0]), .pixel_y(py[0]), .next_pixel_x(npx[0]), .next_pixel_y(npy[0]),
    .hsync(hs[0]), .vsync(vs[0]), .hblank(hb[0]), .vblank(vb[0]),
    .video_on(von[0]), .next_video_on(nvon[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc_d)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .FCW(2)
  ) dut_s (
    .pixel_clk(clk), .reset_n(reset_n), .vtg_ce(ce),
    .pixel_x(px[1]), .pixel_y(py[1]), .next_pixel_x(npx[1]), .next_pixel_y(npy[1]),
    .hsync(hs[1]), .vsync(vs[1]), .hblank(hb[1]), .vblank(vb[1]),
    .video_on(von[1]), .next_video_on(nvon[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc_s)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) dut_m (
    .pixel_clk(clk), .reset_n(reset_n), .vtg_ce(ce),
    .pixel_x(px[2]), .pixel_y(py[2]), .next_pixel_x(npx[2]), .next_pixel_y(npy[2]),
    .hsync(hs[2]), .vsync(vs[2]), .hblank(hb[2]), .vblank(vb[2]),
    .video_on(von[2]), .next_video_on(nvon[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .frame_count(fc_m)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int nxt_x(input int x, input int ht);
    return (x == ht - 1) ? 0 : x + 1;
  endfunction

  function automatic int nxt_y(input int x, input int y, input int ht, input int vt);
    if (x != ht - 1) return y;
    return (y == vt - 1) ? 0 : y + 1;
  endfunction

  // Reference raster: position, strobes and frame counter per instance.
  int mx[3], my[3], mfc[3];
  bit mls[3], mfs[3];

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        mx[i] <= 0; my[i] <= 0; mfc[i] <= 0; mls[i] <= 1'b0; mfs[i] <= 1'b0;
      end else begin
        mls[i] <= 1'b0;
        mfs[i] <= 1'b0;
        if (ce) begin
          mx[i]  <= nxt_x(mx[i], HT[i]);
          my[i]  <= nxt_y(mx[i], my[i], HT[i], VT[i]);
          mls[i] <= (nxt_x(mx[i], HT[i]) == 0);
          if (nxt_x(mx[i], HT[i]) == 0 && nxt_y(mx[i], my[i], HT[i], VT[i]) == 0) begin
            mfs[i] <= 1'b1;
            mfc[i] <= (mfc[i] + 1) % FM[i];
          end
        end
      end
    end
  end

  task automatic score(input int i);
    int x, y, sx, sy, ofc;
    bit ehs, evs;
    string p;
    x   = mx[i];
    y   = my[i];
    sx  = nxt_x(x, HT[i]);
    sy  = nxt_y(x, y, HT[i], VT[i]);
    p   = (i == 0) ? "d" : (i == 1) ? "s" : "m";
    ofc = (i == 0) ? int'(fc_d) : (i == 1) ? int'(fc_s) : int'(fc_m);
    ehs = (x >= HA[i] + HF[i] && x <= HA[i] + HF[i] + HS[i] - 1) ? HP[i] : !HP[i];
    evs = (y >= VA[i] + VF[i] && y <= VA[i] + VF[i] + VS[i] - 1) ? VP[i] : !VP[i];
    check_value({p, "_x"}, px[i], x);
    check_value({p, "_y"}, py[i], y);
    check_value({p, "_nx"}, npx[i], sx);
    check_value({p, "_ny"}, npy[i], sy);
    check_value({p, "_hsync"}, hs[i], ehs);
    check_value({p, "_vsync"}, vs[i], evs);
    check_value({p, "_hblank"}, hb[i], x >= HA[i]);
    check_value({p, "_vblank"}, vb[i], y >= VA[i]);
    check_value({p, "_video_on"}, von[i], (x < HA[i]) && (y < VA[i]));
    check_value({p, "_next_video_on"}, nvon[i], (sx < HA[i]) && (sy < VA[i]));
    check_value({p, "_line_start"}, ls[i], mls[i]);
    check_value({p, "_frame_start"}, fs[i], mfs[i]);
    check_value({p, "_frame_count"}, ofc, mfc[i]);
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      for (int i = 0; i < 3; i++) score(i);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (toggle) ce = ~ce;
    end
  end

  // Waits for the next strobe; counts cycles and cycles where the watched sync is active.
  task automatic wait_strobe(input int sel, input int limit, output int cycles, output int hits);
    logic strobe, watch;
    cycles = 0;
    hits   = 0;
    strobe = 1'b0;
    do begin
      @(negedge clk);
      cycles++;
      case (sel)
        0:       begin strobe = ls[0]; watch = (hs[0] == 1'b0); end
        1:       begin strobe = fs[1]; watch = vs[1]; end
        default: begin strobe = fs[2]; watch = (vs[2] == 1'b0); end
      endcase
      if (watch) hits++;
    end while (!strobe && cycles < limit);
    check_value("strobe_seen", strobe, 1'b1);
  endtask

  initial begin
    int cyc, hits, fc0;
    #1 reset_n = 1'b0;
    #1 sb_en = 1'b1;
    check_value("rst_x", px[0], 0);
    check_value("rst_nx", npx[0], 1);
    check_value("rst_video_on", von[0], 1);
    check_value("rst_next_video_on", nvon[0], 1);
    check_value("rst_hsync_d", hs[0], 1);
    check_value("rst_hsync_s", hs[1], 0);
    check_value("rst_vsync_s", vs[1], 0);
    check_value("rst_frame_count", fc_d, 0);
    #30 reset_n = 1'b1;

    @(negedge clk);
    check_value("first_edge_x", px[0], 1);
    check_value("first_edge_line_start", ls[0], 0);
    check_value("first_edge_frame_start", fs[1], 0);

    wait_strobe(0, 2000, cyc, hits);
    wait_strobe(0, 2000, cyc, hits);
    check_value("d_line_period", cyc, 800);
    check_value("d_hsync_low_cycles", hits, 96);

    wait_strobe(2, 9000, cyc, hits);
    check_value("m_frame_count_first", fc_m, 1);
    wait_strobe(2, 9000, cyc, hits);
    check_value("m_frame_period", cyc, 4200);
    check_value("m_vsync_low_cycles", hits, 16);
    check_value("m_frame_count_second", fc_m, 2);

    wait_strobe(1, 100, cyc, hits);
    fc0 = int'(fc_s);
    for (int k = 0; k < 4; k++) begin
      wait_strobe(1, 100, cyc, hits);
      check_value("s_frame_period", cyc, 48);
      check_value("s_vsync_high_cycles", hits, 8);
    end
    check_value("s_frame_count_wrap", fc_s, fc0);

    toggle = 1'b1;
    wait_strobe(2, 20000, cyc, hits);
    wait_strobe(2, 20000, cyc, hits);
    check_value("m_frame_period_half_rate", cyc, 8400);
    wait_strobe(1, 300, cyc, hits);
    wait_strobe(1, 300, cyc, hits);
    check_value("s_frame_period_half_rate", cyc, 96);
    toggle = 1'b0;
    @(negedge clk);
    ce = 1'b1;

    for (int k = 0; k < 1000 && px[0] != 10'd700; k++) @(negedge clk);
    check_value("d_reach_x700", px[0], 700);
    #2 reset_n = 1'b0;
    #1;
    check_value("async_rst_x", px[0], 0);
    check_value("async_rst_y", py[0], 0);
    check_value("async_rst_nx", npx[0], 1);
    check_value("async_rst_hsync", hs[0], 1);
    check_value("async_rst_hblank", hb[0], 0);
    check_value("async_rst_video_on", von[0], 1);
    check_value("async_rst_vsync_m", vs[2], 1);
    check_value("async_rst_fc_m", fc_m, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check_value("restart_x", px[0], 1);
    check_value("restart_y", py[0], 0);
    check_value("restart_line_start", ls[0], 0);
    check_value("restart_frame_start", fs[2], 0);
    check_value("restart_frame_count", fc_d, 0);
    repeat (50) @(negedge clk);
    sb_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
